// File: rtl/uart_loader.sv
// UART program loader: receives an 8N1 byte stream framed as A5, LEN0, LEN1, payload, CSUM
// and issues one memory write strobe per assembled DATA_WIDTH word.
module uart_loader #(
   parameter int          CLK_FREQ    = 50_000_000,
   parameter int          UART_BPS    = 19200,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          ADDR_STEP   = 4,
   parameter int          SYNC_STAGES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  debug_en_i,
   input  logic                  uart_rx,
   output logic                  rib_wr_req_o,
   output logic                  mem_wr_en_o,
   output logic [31:0]           mem_wr_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wr_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            err_o
);

   localparam int                BAUD_DIV  = CLK_FREQ / UART_BPS;
   localparam int                NB        = DATA_WIDTH / 8;
   localparam int                CNT_W     = $clog2(BAUD_DIV);
   localparam int                BI_W      = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BAUD_DIV - 1);
   localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NB - 1);
   localparam logic [31:0]       STEP      = 32'(ADDR_STEP);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_SYNC, P_LEN0, P_LEN1, P_DATA, P_CSUM} p_state_t;

   logic [SYNC_STAGES-1:0] r_en_sync;
   logic [SYNC_STAGES-1:0] r_rx_sync;
   logic                   r_rx_prev;
   logic                   r_rib_wr_req;
   logic                   w_en;
   logic                   w_clear;
   logic                   w_rx;
   logic                   w_rx_fall;

   rx_state_t              r_rx_state, w_rx_next;
   logic [CNT_W-1:0]       r_baud_cnt;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic                   r_byte_valid;
   logic                   r_frame_err;
   logic                   w_bit_end, w_cnt_clr, w_shift_en, w_stop_ok, w_stop_bad;

   p_state_t               r_p_state, w_p_next;
   logic [15:0]            r_len;
   logic [15:0]            r_word_idx;
   logic [BI_W-1:0]        r_byte_idx;
   logic [7:0]             r_csum;
   logic [31:0]            r_next_addr;
   logic [DATA_WIDTH-1:0]  r_word;
   logic                   r_wr_en;
   logic [31:0]            r_wr_addr;
   logic [DATA_WIDTH-1:0]  r_wr_data;
   logic                   r_done;
   logic [1:0]             r_err;
   logic                   w_sync_hit, w_data_byte, w_last_byte, w_csum_byte;
   logic [DATA_WIDTH-1:0]  w_word_next;

   // The enable synchroniser and bus request only see the hard reset; everything else
   // also clears while the synchronised enable is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en_sync    <= '0;
         r_rib_wr_req <= 1'b0;
      end else begin
         r_en_sync    <= {r_en_sync[SYNC_STAGES-2:0], debug_en_i};
         r_rib_wr_req <= w_en;
      end
   end

   assign w_en      = r_en_sync[SYNC_STAGES-1];
   assign w_clear   = !rst_n || !w_en;
   assign w_rx      = r_rx_sync[SYNC_STAGES-1];
   assign w_rx_fall = r_rx_prev && !w_rx;
   assign w_bit_end = (r_baud_cnt == FULL_CNT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_rx_sync <= '1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], uart_rx};
         r_rx_prev <= w_rx;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) r_rx_state <= RX_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   // NOTE: combinational blocks assign defaults first so no path leaves a latch behind.
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
         RX_START: if (r_baud_cnt == HALF_CNT) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_rx_next = RX_STOP;
         RX_STOP:  if (w_bit_end) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_clr  = 1'b0;
      w_shift_en = 1'b0;
      w_stop_ok  = 1'b0;
      w_stop_bad = 1'b0;
      case (r_rx_state)
         RX_IDLE:  w_cnt_clr = 1'b1;
         RX_START: w_cnt_clr = (r_baud_cnt == HALF_CNT);
         RX_DATA: begin
            w_cnt_clr  = w_bit_end;
            w_shift_en = w_bit_end;
         end
         RX_STOP: begin
            w_stop_ok  = w_bit_end && w_rx;
            w_stop_bad = w_bit_end && !w_rx;
         end
         default: w_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_baud_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_baud_cnt   <= w_cnt_clr ? '0 : r_baud_cnt + 1'b1;
         r_byte_valid <= w_stop_ok;
         r_frame_err  <= w_stop_bad;
         if (r_rx_state == RX_IDLE) r_bit_cnt <= '0;
         else if (w_shift_en)       r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_shift_en) r_shift <= {w_rx, r_shift[7:1]};
      end
   end

   // r_shift holds the received byte until the next start bit's data phase, well after use.
   always_ff @(posedge clk) begin
      if (w_clear) r_p_state <= P_SYNC;
      else         r_p_state <= w_p_next;
   end

   always_comb begin
      w_p_next = r_p_state;
      if (r_frame_err) begin
         w_p_next = P_SYNC;
      end else if (r_byte_valid) begin
         case (r_p_state)
            P_SYNC:  if (r_shift == 8'hA5) w_p_next = P_LEN0;
            P_LEN0:  w_p_next = P_LEN1;
            P_LEN1:  w_p_next = ({r_shift, r_len[7:0]} == 16'd0) ? P_CSUM : P_DATA;
            P_DATA:  if ((r_byte_idx == LAST_BYTE) && (r_word_idx == r_len - 16'd1))
                        w_p_next = P_CSUM;
            P_CSUM:  w_p_next = P_SYNC;
            default: w_p_next = P_SYNC;
         endcase
      end
   end

   always_comb begin
      w_sync_hit  = r_byte_valid && (r_p_state == P_SYNC) && (r_shift == 8'hA5);
      w_data_byte = r_byte_valid && (r_p_state == P_DATA);
      w_last_byte = w_data_byte && (r_byte_idx == LAST_BYTE);
      w_csum_byte = r_byte_valid && (r_p_state == P_CSUM);
      w_word_next = r_word;
      for (int k = 0; k < NB; k++) begin
         if (r_byte_idx == BI_W'(k)) w_word_next[8*k +: 8] = r_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_len       <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_csum      <= '0;
         r_next_addr <= BASE_ADDR;
         r_word      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_done      <= 1'b0;
         r_err       <= 2'b00;
      end else begin
         r_wr_en <= w_last_byte;
         r_done  <= w_csum_byte && (r_shift == r_csum);
         if (r_frame_err) r_err[0] <= 1'b1;
         if (w_csum_byte && (r_shift != r_csum)) r_err[1] <= 1'b1;
         if (w_sync_hit) begin
            r_csum      <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_next_addr <= BASE_ADDR;
         end
         if (r_byte_valid && (r_p_state == P_LEN0)) r_len[7:0]  <= r_shift;
         if (r_byte_valid && (r_p_state == P_LEN1)) r_len[15:8] <= r_shift;
         if (w_data_byte) begin
            r_csum <= r_csum + r_shift;
            r_word <= w_word_next;
            if (w_last_byte) begin
               r_byte_idx  <= '0;
               r_word_idx  <= r_word_idx + 16'd1;
               r_wr_data   <= w_word_next;
               r_wr_addr   <= r_next_addr;
               r_next_addr <= r_next_addr + STEP;
            end else begin
               r_byte_idx <= r_byte_idx + 1'b1;
            end
         end
      end
   end

   assign rib_wr_req_o  = r_rib_wr_req;
   assign mem_wr_en_o   = r_wr_en;
   assign mem_wr_addr_o = r_wr_addr;
   assign mem_wr_data_o = r_wr_data;
   assign busy_o        = (r_p_state != P_SYNC);
   assign done_o        = r_done;
   assign err_o         = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a 32-bit instance and a 16-bit instance (BASE 0x100, STEP 2), both at
// 16 clocks per bit, checked against a frame-level model of the expected writes, done and errors.
module tb_uart_loader;

   localparam int BD = 16;

   logic        clk = 1'b0;
   logic        rst_n, debug_en, rx_a, rx_b;
   logic        rib_a, wen_a, busy_a, done_a;
   logic [31:0] addr_a, data_a;
   logic [1:0]  err_a;
   logic        rib_b, wen_b, busy_b, done_b;
   logic [31:0] addr_b;
   logic [15:0] data_b;
   logic [1:0]  err_b;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   int          got_done[2] = '{0, 0};
   int          exp_done[2] = '{0, 0};
   logic [1:0]  exp_err[2]  = '{2'b00, 2'b00};

   always #5 clk = ~clk;

   uart_loader #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .DATA_WIDTH(32),
                 .BASE_ADDR(32'h0), .ADDR_STEP(4), .SYNC_STAGES(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .debug_en_i(debug_en), .uart_rx(rx_a),
      .rib_wr_req_o(rib_a), .mem_wr_en_o(wen_a), .mem_wr_addr_o(addr_a),
      .mem_wr_data_o(data_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

   uart_loader #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .DATA_WIDTH(16),
                 .BASE_ADDR(32'h100), .ADDR_STEP(2), .SYNC_STAGES(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .debug_en_i(debug_en), .uart_rx(rx_b),
      .rib_wr_req_o(rib_b), .mem_wr_en_o(wen_b), .mem_wr_addr_o(addr_b),
      .mem_wr_data_o(data_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

   always @(negedge clk) begin
      if (wen_a)  got_a.push_back({addr_a, data_a});
      if (wen_b)  got_b.push_back({addr_b, 16'h0000, data_b});
      if (done_a) got_done[0]++;
      if (done_b) got_done[1]++;
   end

   function automatic logic [7:0] sum8(input logic [7:0] pl[$]);
      logic [7:0] s = 8'h00;
      foreach (pl[i]) s += pl[i];
      return s;
   endfunction

   // Frame-level expectation: N little-endian words at BASE + w*STEP, then done or err[1].
   function automatic void model_frame(input int sel, input int n, input logic [7:0] pl[$],
                                       input logic [7:0] csum);
      int          nb   = (sel == 0) ? 4 : 2;
      logic [31:0] base = (sel == 0) ? 32'h0 : 32'h100;
      int          step = (sel == 0) ? 4 : 2;
      for (int w = 0; w < n; w++) begin
         logic [31:0] d = 32'h0;
         for (int k = 0; k < nb; k++) d |= 32'(pl[w*nb + k]) << (8*k);
         if (sel == 0) exp_a.push_back({base + 32'(w*step), d});
         else          exp_b.push_back({base + 32'(w*step), d});
      end
      if (sum8(pl) == csum) exp_done[sel]++;
      else                  exp_err[sel][1] = 1'b1;
   endfunction

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else          rx_b = v;
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
      set_rx(sel, 1'b0);
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, b[i]);
         repeat (BD) @(negedge clk);
      end
      set_rx(sel, stop);
      repeat (BD) @(negedge clk);
      set_rx(sel, 1'b1);
   endtask

   task automatic send_frame(input int sel, input int n, input logic [7:0] pl[$],
                             input logic [7:0] csum);
      model_frame(sel, n, pl, csum);
      send_byte(sel, 8'hA5, 1'b1);
      send_byte(sel, n[7:0], 1'b1);
      send_byte(sel, n[15:8], 1'b1);
      foreach (pl[i]) send_byte(sel, pl[i], 1'b1);
      send_byte(sel, csum, 1'b1);
   endtask

   task automatic clear_sb();
      got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
      got_done = '{0, 0};
      exp_done = '{0, 0};
   endtask

   task automatic soft_clear();
      debug_en = 1'b0;
      repeat (10) @(negedge clk);
      debug_en = 1'b1;
      repeat (10) @(negedge clk);
      exp_err = '{2'b00, 2'b00};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; debug_en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({rib_a, wen_a, busy_a, done_a, err_a} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl_a: got %b want 000000", {rib_a, wen_a, busy_a, done_a, err_a});
      end
      checks++;
      if ({addr_a, data_a} !== 64'h0) begin
         errors++; $display("FAIL reset_bus_a: got %h want 0", {addr_a, data_a});
      end
      checks++;
      if ({rib_b, wen_b, busy_b, done_b, err_b, addr_b, data_b} !== 54'h0) begin
         errors++; $display("FAIL reset_b: got %h want 0", {rib_b, wen_b, busy_b, done_b, err_b, addr_b, data_b});
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if ({rib_a, rib_b, busy_a} !== 3'b110) begin
         errors++; $display("FAIL reset_release: got %b want 110", {rib_a, rib_b, busy_a});
      end
   endtask

   task automatic test_basic();
      logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      clear_sb();
      send_frame(0, 2, pl, sum8(pl));
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== 2) begin
         errors++; $display("FAIL basic_count: got %0d want 2", got_a.size());
      end else begin
         checks++;
         if (got_a[0] !== {32'h0, 32'h44332211} || got_a[1] !== {32'h4, 32'h88776655}) begin
            errors++; $display("FAIL basic_words: got %h %h want 0/44332211 4/88776655", got_a[0], got_a[1]);
         end
      end
      checks++;
      if (got_done[0] !== 1 || err_a !== 2'b00 || busy_a !== 1'b0) begin
         errors++; $display("FAIL basic_status: got done=%0d err=%b busy=%b want 1 00 0", got_done[0], err_a, busy_a);
      end
   endtask

   task automatic test_bad_csum();
      logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      clear_sb();
      send_frame(0, 2, pl, 8'h00);
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== exp_a.size() || (got_a.size() == 2 && (got_a[0] !== exp_a[0] || got_a[1] !== exp_a[1]))) begin
         errors++; $display("FAIL badcsum_writes: got %0d writes want %0d", got_a.size(), exp_a.size());
      end
      checks++;
      if (got_done[0] !== 0 || err_a !== 2'b10) begin
         errors++; $display("FAIL badcsum_status: got done=%0d err=%b want 0 10", got_done[0], err_a);
      end
   endtask

   task automatic test_framing();
      logic [7:0] pl[$] = '{8'h5A, 8'h3C, 8'h96, 8'h0F};
      soft_clear();
      clear_sb();
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h02, 1'b1);
      send_byte(0, 8'h00, 1'b0);
      exp_err[0][0] = 1'b1;
      repeat (3*BD) @(negedge clk);
      checks++;
      if (err_a !== 2'b01 || busy_a !== 1'b0 || got_a.size() !== 0) begin
         errors++; $display("FAIL framing_err: got err=%b busy=%b writes=%0d want 01 0 0", err_a, busy_a, got_a.size());
      end
      send_byte(0, 8'h11, 1'b1);
      send_byte(0, 8'h22, 1'b1);
      send_frame(0, 1, pl, sum8(pl));
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== 1 || (got_a.size() == 1 && got_a[0] !== {32'h0, 32'h0F963C5A})) begin
         errors++; $display("FAIL framing_recover: got %0d writes want 1 at 0 = 0f963c5a", got_a.size());
      end
      checks++;
      if (got_done[0] !== 1 || err_a !== exp_err[0]) begin
         errors++; $display("FAIL framing_status: got done=%0d err=%b want 1 %b", got_done[0], err_a, exp_err[0]);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] pl[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      soft_clear();
      clear_sb();
      rx_a = 1'b0;
      repeat (BD/4) @(negedge clk);
      rx_a = 1'b1;
      repeat (3*BD) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || err_a !== 2'b00) begin
         errors++; $display("FAIL glitch_state: got busy=%b err=%b want 0 00", busy_a, err_a);
      end
      send_byte(0, 8'h00, 1'b1);
      send_byte(0, 8'h13, 1'b1);
      send_frame(0, 1, pl, sum8(pl));
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== 1 || (got_a.size() == 1 && got_a[0] !== {32'h0, 32'hEFBEADDE}) ||
          got_done[0] !== 1 || err_a !== 2'b00) begin
         errors++; $display("FAIL glitch_frame: got writes=%0d done=%0d err=%b want 1 1 00", got_a.size(), got_done[0], err_a);
      end
   endtask

   task automatic test_width16();
      logic [7:0] pl[$] = '{8'hCD, 8'hAB};
      clear_sb();
      send_frame(1, 1, pl, 8'h78);
      repeat (20) @(negedge clk);
      checks++;
      if (got_b.size() !== 1 || (got_b.size() == 1 && got_b[0] !== {32'h100, 32'h0000ABCD})) begin
         errors++; $display("FAIL w16_write: got %0d writes first=%h want 1 100/abcd", got_b.size(),
                            (got_b.size() > 0) ? got_b[0] : 64'h0);
      end
      checks++;
      if (got_done[1] !== 1 || err_b !== 2'b00) begin
         errors++; $display("FAIL w16_status: got done=%0d err=%b want 1 00", got_done[1], err_b);
      end
   endtask

   task automatic test_soft_clear();
      logic [7:0] empty[$];
      soft_clear();
      clear_sb();
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h02, 1'b1);
      send_byte(0, 8'h00, 1'b1);
      send_byte(0, 8'h11, 1'b1);
      send_byte(0, 8'h22, 1'b1);
      checks++;
      if (busy_a !== 1'b1) begin
         errors++; $display("FAIL clr_busy_mid: got %b want 1", busy_a);
      end
      debug_en = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || rib_a !== 1'b0 || got_a.size() !== 0) begin
         errors++; $display("FAIL clr_drop: got busy=%b rib=%b writes=%0d want 0 0 0", busy_a, rib_a, got_a.size());
      end
      debug_en = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (rib_a !== 1'b1) begin
         errors++; $display("FAIL clr_rib_back: got %b want 1", rib_a);
      end
      send_byte(0, 8'h33, 1'b1);
      send_byte(0, 8'h44, 1'b1);
      send_frame(0, 0, empty, 8'h00);
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== 0 || got_done[0] !== 1 || err_a !== 2'b00 || busy_a !== 1'b0) begin
         errors++; $display("FAIL clr_n0_frame: got writes=%0d done=%0d err=%b busy=%b want 0 1 00 0",
                            got_a.size(), got_done[0], err_a, busy_a);
      end
   endtask

   task automatic test_back_to_back();
      soft_clear();
      clear_sb();
      for (int r = 0; r < 6; r++) begin
         int         sel  = int'($urandom_range(0, 1));
         int         n    = int'($urandom_range(1, 3));
         int         nb   = (sel == 0) ? 4 : 2;
         int         pre  = int'($urandom_range(0, 2));
         logic [7:0] pl[$];
         logic [7:0] cs;
         for (int g = 0; g < pre; g++) begin
            logic [7:0] gb = 8'($urandom_range(0, 255));
            if (gb == 8'hA5) gb = 8'h5A;
            send_byte(sel, gb, 1'b1);
         end
         for (int i = 0; i < n*nb; i++) pl.push_back(8'($urandom_range(0, 255)));
         cs = sum8(pl);
         if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
         send_frame(sel, n, pl, cs);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (got_a.size() !== exp_a.size() || got_b.size() !== exp_b.size()) begin
         errors++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
      end else begin
         foreach (exp_a[i]) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
               errors++; $display("FAIL b2b_a[%0d]: got %h want %h", i, got_a[i], exp_a[i]);
            end
         end
         foreach (exp_b[i]) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
               errors++; $display("FAIL b2b_b[%0d]: got %h want %h", i, got_b[i], exp_b[i]);
            end
         end
      end
      checks++;
      if (got_done[0] !== exp_done[0] || got_done[1] !== exp_done[1] || err_a !== exp_err[0] || err_b !== exp_err[1]) begin
         errors++; $display("FAIL b2b_status: got done=%0d/%0d err=%b/%b want %0d/%0d %b/%b", got_done[0], got_done[1],
                            err_a, err_b, exp_done[0], exp_done[1], exp_err[0], exp_err[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_csum();
      test_framing();
      test_glitch();
      test_width16();
      test_soft_clear();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
